// File: rtl/stack_ctrl_if.sv
// Command/response and stack-RAM signals of the operand stack controller.
// The slave modport is the controller; the master side is the control unit plus RAM.
interface stack_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              push;
  logic              pop;
  logic              tos;
  logic [DATA_W-1:0] din;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  push, pop, tos, din, clr_err, ram_rdata,
    output dout, busy, done, full, empty, overflow, underflow,
           ram_addr, ram_wdata, ram_we, ram_re
  );

  modport master (
    output push, pop, tos, din, clr_err, ram_rdata,
    input  dout, busy, done, full, empty, overflow, underflow,
           ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/stack_ctrl.sv
// Operand stack sequencer: turns push/pop/tos pulses into single-port RAM
// accesses, tracks the element count and flags overflow/underflow.
module stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  stack_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WR, RD, RDW, ERR} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              is_pop;
  logic [DATA_W-1:0] dout_q;
  logic              done_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              full_w;
  logic              empty_w;

  assign full_w  = (count == FULL_CNT);
  assign empty_w = (count == '0);

  // RAM strobes come straight from the state, so an async reset kills an
  // in-flight write at once.
  assign bus.ram_we    = (state == WR);
  assign bus.ram_re    = (state == RD);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = data_q;

  assign bus.dout      = dout_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE);
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // Error flags are cleared first so that a coincident error event wins.
  // The top address uses only the low count bits: count=DEPTH wraps to DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      is_pop      <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clr_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.push) begin
            if (full_w) begin
              overflow_q <= 1'b1;
              state      <= ERR;
            end else begin
              addr_q <= count[ADDR_W-1:0];
              data_q <= bus.din;
              state  <= WR;
            end
          end else if (bus.pop || bus.tos) begin
            if (empty_w) begin
              underflow_q <= 1'b1;
              state       <= ERR;
            end else begin
              addr_q <= count[ADDR_W-1:0] - 1'b1;
              is_pop <= bus.pop;
              state  <= RD;
            end
          end
        end
        WR: begin
          count  <= count + 1'b1;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        RD: begin
          state <= RDW;
        end
        RDW: begin
          dout_q <= bus.ram_rdata;
          done_q <= 1'b1;
          if (is_pop) begin
            count <= count - 1'b1;
          end
          state <= IDLE;
        end
        ERR: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a queue-based stack model checked every cycle,
// plus directed scenarios with hand-computed values.
module tb_stack_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  stack_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  stack_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read stack RAM; deliberately not reset.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr];
  end

  typedef enum {K_NONE, K_PUSH, K_POP, K_TOS, K_ERR} kind_t;

  logic [7:0] mstack [$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_unf;
  logic       m_done;
  logic [7:0] m_pval;
  int         m_left;
  kind_t      m_kind;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation takes 1 cycle (push/error) or 2 cycles (read) after
  // acceptance, and its effect on the stack becomes visible with done.
  initial begin
    m_kind = K_NONE;
    m_left = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mstack.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_done = 1'b0;
        m_left = 0;
        m_kind = K_NONE;
      end else begin
        m_done = 1'b0;
        if (bus.clr_err) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            case (m_kind)
              K_PUSH:  mstack.push_back(m_pval);
              K_POP:   m_dout = mstack.pop_back();
              K_TOS:   m_dout = mstack[mstack.size()-1];
              default: ;
            endcase
          end
        end else if (bus.push) begin
          if (mstack.size() == 16) begin
            m_ovf  = 1'b1;
            m_kind = K_ERR;
          end else begin
            m_kind = K_PUSH;
            m_pval = bus.din;
          end
          m_left = 1;
        end else if (bus.pop || bus.tos) begin
          if (mstack.size() == 0) begin
            m_unf  = 1'b1;
            m_kind = K_ERR;
            m_left = 1;
          end else begin
            m_kind = bus.pop ? K_POP : K_TOS;
            m_left = 2;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic exp_we;
    logic exp_re;
    int   sz;
    forever begin
      @(negedge clk);
      sz     = mstack.size();
      exp_we = (m_left > 0) && (m_kind == K_PUSH);
      exp_re = (m_left == 2) && (m_kind == K_POP || m_kind == K_TOS);
      checkOutput("cyc_busy",      32'(bus.busy),      32'(m_left > 0));
      checkOutput("cyc_done",      32'(bus.done),      32'(m_done));
      checkOutput("cyc_full",      32'(bus.full),      32'(sz == 16));
      checkOutput("cyc_empty",     32'(bus.empty),     32'(sz == 0));
      checkOutput("cyc_overflow",  32'(bus.overflow),  32'(m_ovf));
      checkOutput("cyc_underflow", 32'(bus.underflow), 32'(m_unf));
      checkOutput("cyc_dout",      32'(bus.dout),      32'(m_dout));
      checkOutput("cyc_ram_we",    32'(bus.ram_we),    32'(exp_we));
      checkOutput("cyc_ram_re",    32'(bus.ram_re),    32'(exp_re));
      if (exp_we) begin
        checkOutput("cyc_wr_addr",  32'(bus.ram_addr),  32'(sz));
        checkOutput("cyc_wr_data",  32'(bus.ram_wdata), 32'(m_pval));
      end
      if (exp_re) checkOutput("cyc_rd_addr", 32'(bus.ram_addr), 32'(sz - 1));
    end
  end

  // Drives one request pulse and waits (bounded) for done; lat counts cycles
  // from the sampling edge to the done cycle.
  task automatic applyStimulus(input logic p, input logic po, input logic t, input logic [7:0] d,
                               output int lat, output logic we1, output logic [3:0] a1);
    bus.push = p;
    bus.pop  = po;
    bus.tos  = t;
    bus.din  = d;
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.tos  = 1'b0;
    we1 = bus.ram_we;
    a1  = bus.ram_addr;
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulseClr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       we1;
    logic [3:0] a1;
    logic [7:0] vals [3];
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.tos = 1'b0;
    bus.din = 8'h00;
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_dout",  32'(bus.dout),   32'h0);
    checkOutput("rst_busy",  32'(bus.busy),   32'h0);
    checkOutput("rst_empty", 32'(bus.empty),  32'h1);
    checkOutput("rst_we",    32'(bus.ram_we), 32'h0);
    checkOutput("rst_addr",  32'(bus.ram_addr), 32'h0);
    #2 rst = 1'b0;
    @(negedge clk);

    $display("[TB] push 3, pop 3");
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, vals[i], lat, we1, a1);
      checkOutput("t1_push_lat", 32'(lat), 32'd2);
      checkOutput("t1_we",       32'(we1), 32'h1);
      checkOutput("t1_addr",     32'(a1),  32'(i));
    end
    for (int i = 2; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
      checkOutput("t1_pop_lat",  32'(lat),      32'd3);
      checkOutput("t1_pop_dout", 32'(bus.dout), 32'(vals[i]));
    end
    checkOutput("t1_empty", 32'(bus.empty), 32'h1);

    $display("[TB] tos is non-destructive");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A, lat, we1, a1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, lat, we1, a1);
      checkOutput("t2_tos_dout", 32'(bus.dout),  32'h5A);
      checkOutput("t2_tos_cnt",  32'(bus.empty), 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
    checkOutput("t2_pop_dout", 32'(bus.dout),  32'h5A);
    checkOutput("t2_empty",    32'(bus.empty), 32'h1);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h80 + i), lat, we1, a1);
      checkOutput("t3_fill_addr", 32'(a1), 32'(i));
    end
    checkOutput("t3_full", 32'(bus.full), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, lat, we1, a1);
    checkOutput("t3_ovf_lat", 32'(lat),          32'd2);
    checkOutput("t3_ovf_we",  32'(we1),          32'h0);
    checkOutput("t3_ovf",     32'(bus.overflow), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
    checkOutput("t3_pop16",  32'(bus.dout),     32'h8F);
    checkOutput("t3_ovf_hold", 32'(bus.overflow), 32'h1);
    pulseClr();
    checkOutput("t3_clr", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
      checkOutput("t3_drain", 32'(bus.dout), 32'(8'(8'h8E - i)));
    end
    checkOutput("t3_empty", 32'(bus.empty), 32'h1);

    $display("[TB] underflow");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
    checkOutput("t4_unf_lat",  32'(lat),           32'd2);
    checkOutput("t4_unf",      32'(bus.underflow), 32'h1);
    checkOutput("t4_unf_dout", 32'(bus.dout),      32'h80);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, lat, we1, a1);
    checkOutput("t4_tos_lat",  32'(lat),      32'd2);
    checkOutput("t4_tos_dout", 32'(bus.dout), 32'h80);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h12, lat, we1, a1);
    checkOutput("t4_push_we",   32'(we1), 32'h1);
    checkOutput("t4_push_addr", 32'(a1),  32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, lat, we1, a1);
    checkOutput("t4_tos", 32'(bus.dout), 32'h12);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
    checkOutput("t4_pop", 32'(bus.dout), 32'h12);
    pulseClr();
    checkOutput("t4_clr", 32'(bus.underflow), 32'h0);

    $display("[TB] priority and busy requests");
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    bus.din  = 8'h44;
    @(negedge clk);
    bus.pop = 1'b0;
    bus.din = 8'h99;
    checkOutput("t5_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    bus.push = 1'b0;
    checkOutput("t5_done", 32'(bus.done), 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("t5_idle", 32'(bus.busy), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, lat, we1, a1);
    checkOutput("t5_tos", 32'(bus.dout), 32'h44);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
    checkOutput("t5_pop",   32'(bus.dout),  32'h44);
    checkOutput("t5_empty", 32'(bus.empty), 32'h1);

    $display("[TB] reset during write");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h01, lat, we1, a1);
    bus.push = 1'b1;
    bus.din  = 8'h77;
    @(negedge clk);
    bus.push = 1'b0;
    checkOutput("t6_we_pre", 32'(bus.ram_we), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_we",    32'(bus.ram_we), 32'h0);
    checkOutput("t6_busy",  32'(bus.busy),   32'h0);
    checkOutput("t6_done",  32'(bus.done),   32'h0);
    checkOutput("t6_empty", 32'(bus.empty),  32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hAB, lat, we1, a1);
    checkOutput("t6_re_we",   32'(we1), 32'h1);
    checkOutput("t6_re_addr", 32'(a1),  32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, lat, we1, a1);
    checkOutput("t6_pop", 32'(bus.dout), 32'hAB);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
